segway_math_pipe: RTL and testbench
===================================

# segway_math_pipe

Parametrised, pipelined successor to the balance-controller math block. It converts the PID output, soft-start timer and steering-pot reading into signed left/right wheel speed commands. It adds a valid-tagged 3-stage pipeline, per-wheel slew-rate limiting and a debounced `too_fast` flag. It sits between the balance controller (PID) and the motor-drive/PWM block.

## Interface
Parameters:
- `WIDTH`, 12: signed width of `PID_cntrl`, `lft_spd`, `rght_spd`.
- `MIN_DUTY`, 13'h3C0: dead-band offset added or subtracted outside the low-torque band.
- `LOW_TORQUE_BAND`, 8'h3C: magnitude threshold between the gain zone and the offset zone.
- `GAIN_MULT`, 6'h10: multiplier inside the low-torque band.
- `STEER_GAIN`, 3: multiplier applied to the scaled steer term.
- `SLEW_STEP`, 0: maximum per-sample change of each speed output; 0 disables limiting.
- `TOO_FAST_THR`, 1792: positive speed threshold.
- `TOO_FAST_CNT`, 4: number of consecutive valid over-threshold samples before `too_fast` asserts.

Ports:
- `clk` in 1: clock. Every transfer happens on the rising edge.
- `rst_n` in 1: reset. The block has one clock; reset is synchronous and active-low.
- `vld_in` in 1: the input sample is valid this cycle.
- `PID_cntrl` in WIDTH: signed PID output.
- `ss_tmr` in 8: unsigned soft-start scale.
- `steer_pot` in 12: unsigned A2D steering reading.
- `en_steer` in 1: enable the steer contribution.
- `pwr_up` in 1: 0 forces both speeds to 0.
- `vld_out` in/out: out, 1 bit: speed outputs updated this cycle.
- `lft_spd`, `rght_spd` out WIDTH: signed speed commands, held between valid samples.
- `too_fast` out 1: debounced over-speed flag.

## Operation
- Stage 1 (registered with `vld_in`, `en_steer`, `pwr_up`):
  - `pid_ss = (PID_cntrl * {1'b0,ss_tmr}) >>> 8`, WIDTH+1 bits signed.
  - `steer_pot` is clipped to [0x200, 0xE00].
  - `steer = ((clip - 0x7FF) >>> 4) * STEER_GAIN`, signed.
- Stage 2, torque:
  - `lft = pid_ss + steer` and `rght = pid_ss - steer` when `en_steer`; otherwise both equal `pid_ss`.
  - Both are computed at WIDTH+1 bits.
- Stage 2, shaping:
  - If `|t| > LOW_TORQUE_BAND`, the result is `t ± MIN_DUTY`, using the sign of `t`.
  - Otherwise the result is `t * GAIN_MULT`.
  - If `pwr_up` = 0, the result is 0.
  - The shaped value is saturated to WIDTH signed, i.e. [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Stage 3, slew (only on a valid sample):
  - `d = target - cur`, computed at WIDTH+1 bits.
  - If `d > SLEW_STEP`, `cur += SLEW_STEP`.
  - If `d < -SLEW_STEP`, `cur -= SLEW_STEP`.
  - Otherwise `cur = target`.
  - The slew is bypassed when `SLEW_STEP` = 0 or when the sample's `pwr_up` = 0; in that case `cur = target`.
- `too_fast` counter (saturating, updated on valid stage-3 samples only):
  - It increments when `lft_spd` or `rght_spd` (post-slew) is greater than `TOO_FAST_THR` (signed compare).
  - Any valid sample that does not meet that condition clears it.
  - `too_fast` = 1 when the count equals `TOO_FAST_CNT`.
  - Negative speeds never trigger it.

## Timing
- Latency: `vld_in` to `vld_out` is exactly 3 cycles.
- Throughput is one sample per cycle. There is no stall and no backpressure.
- Invalid cycles propagate as bubbles. Speed registers and the counter hold through bubbles.
- `too_fast` changes in the same cycle that the triggering `vld_out` is presented.
- Reset (`rst_n` = 0 at an edge) clears, regardless of state and including mid-stream:
  - all pipeline valids;
  - `lft_spd`, `rght_spd`, `too_fast` and the counter, all to 0.
- In-flight samples are discarded on reset. The first `vld_out` after reset is 3 cycles after the first `vld_in` sampled with `rst_n` = 1.
- Simultaneous over-threshold on one wheel and under-threshold on the other counts as over-threshold.
- The counter saturates at `TOO_FAST_CNT`; it does not wrap.

## Structure
- Package `segway_pkg`:
  - the `sat_signed` function (WIDTH+1 bits in, WIDTH bits out);
  - the steer clip constants 12'h200, 12'hE00 and 12'h7FF.
- Sub-module `wheel_shaper`, instantiated twice (left and right):
  - dead-band shaping, `pwr_up` gating, saturation and the slew register;
  - it outputs its current speed.
- The top level holds stage 1, the torque sum/difference, the valid pipe and the `too_fast` counter.

## Test plan
All scenarios use `SLEW_STEP` = 0 unless stated, with `vld_in` held at 1.
- Basic offset zone: `PID_cntrl`=0x100, `ss_tmr`=0xFF, `en_steer`=0, `pwr_up`=1 -> 3 cycles later both speeds = 1215 (0x4BF) and `vld_out`=1.
- Gain zone, both signs:
  - `PID_cntrl`=0x020, `ss_tmr`=0xFF -> both speeds = 496.
  - `PID_cntrl`=-32 -> both speeds = -512.
- Steer: `PID_cntrl`=0, `steer_pot`=0xFFF (clipped to 0xE00), `en_steer`=1 -> `lft_spd`=1248, `rght_spd`=-1248. Then set `en_steer`=0 -> both 0.
- Saturation and `too_fast`:
  - `PID_cntrl`=0x7FF, `ss_tmr`=0xFF -> speeds = 0x7FF.
  - `too_fast` is 0 for the first 3 valid outputs and 1 on the 4th.
  - Insert one sample with `PID_cntrl`=0 -> `too_fast` = 0 on that output.
- Slew with `SLEW_STEP`=64, from 0, target 1215:
  - outputs step 64, 128, … 1152, then 1215 on the 19th valid sample;
  - bubbles in `vld_in` hold the value;
  - `pwr_up`=0 mid-ramp -> next output is 0.
- Reset mid-stream: assert `rst_n`=0 for 1 cycle while `vld_out` = 1 -> all outputs 0 the next cycle, and no `vld_out` from pre-reset samples.

Source files
------------

// File: rtl/segway_pkg.sv
// Shared constants and helpers for the segway wheel-speed math pipeline.
package segway_pkg;

  localparam logic [11:0] STEER_CLIP_LO = 12'h200;
  localparam logic [11:0] STEER_CLIP_HI = 12'hE00;
  localparam logic [11:0] STEER_MID     = 12'h7FF;

  typedef enum logic [1:0] {
    SLEW_TRACK,
    SLEW_UP,
    SLEW_DOWN
  } slew_e;

  // Clamp a sign-extended value into the signed range of a w-bit result.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int                 w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/segway_math_pipe_wheel_shaper.sv
// One wheel: dead-band shaping, power gating and saturation (stage 2),
// followed by the slew-limited speed register (stage 3).
module wheel_shaper
  import segway_pkg::*;
#(
  parameter int WIDTH           = 12,
  parameter int MIN_DUTY        = 'h3C0,
  parameter int LOW_TORQUE_BAND = 'h3C,
  parameter int GAIN_MULT       = 'h10,
  parameter int SLEW_STEP       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_vld1,
  input  logic                    i_pwr1,
  input  logic signed [WIDTH:0]   i_torque,
  input  logic                    i_vld2,
  output logic signed [WIDTH-1:0] o_spd,
  output logic signed [WIDTH-1:0] o_spd_nxt
);

  logic signed [31:0]      w_t;
  logic signed [31:0]      w_abs;
  logic signed [31:0]      w_shaped;
  logic signed [31:0]      w_sat;
  logic signed [31:0]      w_d;
  slew_e                   w_slew;
  logic signed [WIDTH-1:0] w_nxt;
  logic signed [WIDTH-1:0] r_tgt;
  logic signed [WIDTH-1:0] r_spd;
  logic                    r_pwr2;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_t      = 32'(i_torque);
    w_abs    = (w_t < 0) ? -w_t : w_t;
    w_shaped = '0;
    if (i_pwr1) begin
      if (w_abs > LOW_TORQUE_BAND) w_shaped = (w_t < 0) ? w_t - MIN_DUTY : w_t + MIN_DUTY;
      else                         w_shaped = w_t * GAIN_MULT;
    end
    w_sat = sat_signed(w_shaped, WIDTH);
  end

  // NOTE: pure datapath registers are qualified by valid and need no reset; only state that
  // is observable or controls flow (speeds, valids, counter) is reset.
  always_ff @(posedge clk) begin
    if (i_vld1) begin
      r_tgt  <= WIDTH'(w_sat);
      r_pwr2 <= i_pwr1;
    end
  end

  always_comb begin
    w_d    = 32'(r_tgt) - 32'(r_spd);
    w_slew = SLEW_TRACK;
    if (SLEW_STEP != 0 && r_pwr2) begin
      if (w_d > SLEW_STEP)       w_slew = SLEW_UP;
      else if (w_d < -SLEW_STEP) w_slew = SLEW_DOWN;
    end
    case (w_slew)
      SLEW_UP:   w_nxt = WIDTH'(32'(r_spd) + SLEW_STEP);
      SLEW_DOWN: w_nxt = WIDTH'(32'(r_spd) - SLEW_STEP);
      default:   w_nxt = r_tgt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_spd <= '0;
    else if (i_vld2) r_spd <= w_nxt;
  end

  // The next value is exported so the over-speed counter updates on the same edge as the speed.
  assign o_spd_nxt = i_vld2 ? w_nxt : r_spd;
  assign o_spd     = r_spd;

endmodule

// File: rtl/segway_math_pipe.sv
// Converts PID output, soft-start scale and steering pot into slew-limited signed
// left/right wheel speeds through a 3-stage valid-tagged pipeline.
module segway_math_pipe
  import segway_pkg::*;
#(
  parameter int WIDTH           = 12,
  parameter int MIN_DUTY        = 'h3C0,
  parameter int LOW_TORQUE_BAND = 'h3C,
  parameter int GAIN_MULT       = 'h10,
  parameter int STEER_GAIN      = 3,
  parameter int SLEW_STEP       = 0,
  parameter int TOO_FAST_THR    = 1792,
  parameter int TOO_FAST_CNT    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld_in,
  input  logic signed [WIDTH-1:0] PID_cntrl,
  input  logic        [7:0]       ss_tmr,
  input  logic        [11:0]      steer_pot,
  input  logic                    en_steer,
  input  logic                    pwr_up,
  output logic                    vld_out,
  output logic signed [WIDTH-1:0] lft_spd,
  output logic signed [WIDTH-1:0] rght_spd,
  output logic                    too_fast
);

  localparam int CNT_W = $clog2(TOO_FAST_CNT + 1);

  logic signed [WIDTH+8:0] w_prod;
  logic        [11:0]      w_clip;
  logic signed [31:0]      w_off;
  logic signed [31:0]      w_steer;
  logic signed [WIDTH:0]   w_lft;
  logic signed [WIDTH:0]   w_rght;
  logic signed [WIDTH-1:0] w_lft_nxt;
  logic signed [WIDTH-1:0] w_rght_nxt;
  logic                    w_over;

  logic                    r_vld1;
  logic                    r_vld2;
  logic                    r_vld3;
  logic                    r_en1;
  logic                    r_pwr1;
  logic signed [WIDTH:0]   r_pid_ss;
  logic signed [WIDTH:0]   r_steer;
  logic        [CNT_W-1:0] r_tf_cnt;

  // Stage 1: soft-start scaling and centred, clipped steer term.
  always_comb begin
    w_prod = (WIDTH+9)'(PID_cntrl) * (WIDTH+9)'($signed({1'b0, ss_tmr}));
    if (steer_pot < STEER_CLIP_LO)      w_clip = STEER_CLIP_LO;
    else if (steer_pot > STEER_CLIP_HI) w_clip = STEER_CLIP_HI;
    else                                w_clip = steer_pot;
    w_off   = $signed(32'(w_clip)) - $signed(32'(STEER_MID));
    w_steer = (w_off >>> 4) * STEER_GAIN;
  end

  always_ff @(posedge clk) begin
    if (vld_in) begin
      r_pid_ss <= (WIDTH+1)'(w_prod >>> 8);
      r_steer  <= (WIDTH+1)'(w_steer);
      r_en1    <= en_steer;
      r_pwr1   <= pwr_up;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld1 <= 1'b0;
      r_vld2 <= 1'b0;
      r_vld3 <= 1'b0;
    end else begin
      r_vld1 <= vld_in;
      r_vld2 <= r_vld1;
      r_vld3 <= r_vld2;
    end
  end

  // Stage 2 torque split; sum and difference wrap at WIDTH+1 bits.
  always_comb begin
    w_lft  = r_en1 ? r_pid_ss + r_steer : r_pid_ss;
    w_rght = r_en1 ? r_pid_ss - r_steer : r_pid_ss;
  end

  wheel_shaper #(
    .WIDTH(WIDTH), .MIN_DUTY(MIN_DUTY), .LOW_TORQUE_BAND(LOW_TORQUE_BAND),
    .GAIN_MULT(GAIN_MULT), .SLEW_STEP(SLEW_STEP)
  ) u_lft (
    .clk(clk), .rst_n(rst_n), .i_vld1(r_vld1), .i_pwr1(r_pwr1), .i_torque(w_lft),
    .i_vld2(r_vld2), .o_spd(lft_spd), .o_spd_nxt(w_lft_nxt)
  );

  wheel_shaper #(
    .WIDTH(WIDTH), .MIN_DUTY(MIN_DUTY), .LOW_TORQUE_BAND(LOW_TORQUE_BAND),
    .GAIN_MULT(GAIN_MULT), .SLEW_STEP(SLEW_STEP)
  ) u_rght (
    .clk(clk), .rst_n(rst_n), .i_vld1(r_vld1), .i_pwr1(r_pwr1), .i_torque(w_rght),
    .i_vld2(r_vld2), .o_spd(rght_spd), .o_spd_nxt(w_rght_nxt)
  );

  assign w_over = (32'(w_lft_nxt) > TOO_FAST_THR) || (32'(w_rght_nxt) > TOO_FAST_THR);

  // Saturating run-length of consecutive over-threshold valid outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tf_cnt <= '0;
    end else if (r_vld2) begin
      if (!w_over)                                 r_tf_cnt <= '0;
      else if (r_tf_cnt != CNT_W'(TOO_FAST_CNT))   r_tf_cnt <= r_tf_cnt + 1'b1;
    end
  end

  assign too_fast = (r_tf_cnt == CNT_W'(TOO_FAST_CNT));
  assign vld_out  = r_vld3;

endmodule

// File: tb/tb_segway_math_pipe.sv
// Directed bench: two instances (no slew / SLEW_STEP=64) driven by the same stimulus.
module tb_segway_math_pipe;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vld_in;
  logic signed [11:0] pid;
  logic        [7:0]  ss_tmr;
  logic        [11:0] steer_pot;
  logic               en_steer;
  logic               pwr_up;

  logic               vld0, tf0, vld1, tf1;
  logic signed [11:0] lft0, rght0, lft1, rght1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  segway_math_pipe #(.SLEW_STEP(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .PID_cntrl(pid), .ss_tmr(ss_tmr),
    .steer_pot(steer_pot), .en_steer(en_steer), .pwr_up(pwr_up),
    .vld_out(vld0), .lft_spd(lft0), .rght_spd(rght0), .too_fast(tf0)
  );

  segway_math_pipe #(.SLEW_STEP(64)) dut_s64 (
    .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .PID_cntrl(pid), .ss_tmr(ss_tmr),
    .steer_pot(steer_pot), .en_steer(en_steer), .pwr_up(pwr_up),
    .vld_out(vld1), .lft_spd(lft1), .rght_spd(rght1), .too_fast(tf1)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vld_in = 1'b0; pid = '0; ss_tmr = '0;
    steer_pot = 12'h7FF; en_steer = 1'b0; pwr_up = 1'b0;
    cyc(2);
    check("rst_vld", vld0, 0);
    check("rst_lft", lft0, 0);
    check("rst_rght", rght0, 0);
    check("rst_tf", tf0, 0);

    // Offset zone and 3-cycle latency
    rst_n = 1'b1; vld_in = 1'b1; pid = 12'h100; ss_tmr = 8'hFF; pwr_up = 1'b1;
    cyc(2);
    check("lat_vld_early", vld0, 0);
    cyc(1);
    check("lat_vld", vld0, 1);
    check("offset_lft", lft0, 1215);
    check("offset_rght", rght0, 1215);

    // Gain zone, both signs
    pid = 12'h020; cyc(3);
    check("gain_pos_lft", lft0, 496);
    check("gain_pos_rght", rght0, 496);
    pid = 12'hFE0; cyc(3);
    check("gain_neg_lft", lft0, -512);
    check("gain_neg_rght", rght0, -512);

    // Steer, high clip, low clip, disabled
    pid = '0; steer_pot = 12'hFFF; en_steer = 1'b1; cyc(3);
    check("steer_hi_lft", lft0, 1248);
    check("steer_hi_rght", rght0, -1248);
    steer_pot = 12'h000; cyc(3);
    check("steer_lo_lft", lft0, -1248);
    check("steer_lo_rght", rght0, 1248);
    en_steer = 1'b0; cyc(3);
    check("steer_off_lft", lft0, 0);
    check("steer_off_rght", rght0, 0);

    // Negative saturation never trips too_fast
    pid = 12'h800; cyc(3);
    check("sat_neg_lft", lft0, -2048);
    check("sat_neg_rght", rght0, -2048);
    cyc(4);
    check("tf_neg", tf0, 0);

    // Positive saturation and the too_fast debounce
    pid = 12'h7FF; cyc(3);
    check("sat_pos_lft", lft0, 2047);
    check("sat_pos_rght", rght0, 2047);
    check("tf_1", tf0, 0);
    cyc(1); check("tf_2", tf0, 0);
    cyc(1); check("tf_3", tf0, 0);
    cyc(1); check("tf_4", tf0, 1);
    cyc(1); check("tf_5_sat", tf0, 1);
    pid = '0; cyc(1);
    pid = 12'h7FF; cyc(2);
    check("tf_drop_lft", lft0, 0);
    check("tf_drop", tf0, 0);
    cyc(1); check("tf_restart", tf0, 0);
    cyc(3); check("tf_again", tf0, 1);

    // Mid-stream reset
    check("pre_rst_vld", vld0, 1);
    rst_n = 1'b0; cyc(1);
    check("mrst_vld", vld0, 0);
    check("mrst_lft", lft0, 0);
    check("mrst_rght", rght0, 0);
    check("mrst_tf", tf0, 0);
    check("mrst_lft_slew", lft1, 0);
    rst_n = 1'b1; vld_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("post_rst_no_vld", vld0, 0);
    end

    // Slew ramp 0 -> 1215 in steps of 64, with bubbles mid-ramp
    vld_in = 1'b1; pid = 12'h100; ss_tmr = 8'hFF; en_steer = 1'b0; pwr_up = 1'b1;
    cyc(3);
    check("slew_1", lft1, 64);
    for (int i = 2; i <= 5; i++) begin
      cyc(1);
      check("slew_ramp", lft1, 64 * i);
    end
    vld_in = 1'b0;
    cyc(1); check("slew_6", lft1, 384);
    cyc(1); check("slew_7", lft1, 448);
    cyc(1); check("bubble_vld", vld1, 0); check("bubble_hold", lft1, 448);
    vld_in = 1'b1;
    cyc(1); check("bubble_hold2", lft1, 448);
    cyc(1); check("bubble_hold3", rght1, 448);
    cyc(1); check("slew_8", lft1, 512); check("slew_8_vld", vld1, 1);
    for (int i = 9; i <= 18; i++) begin
      cyc(1);
      check("slew_ramp", lft1, 64 * i);
    end
    cyc(1);
    check("slew_19_lft", lft1, 1215);
    check("slew_19_rght", rght1, 1215);

    // Ramp down, then power-off bypasses the slew
    pid = 12'hF00; cyc(3);
    check("slew_dn_1", lft1, 1151);
    cyc(1); check("slew_dn_2", lft1, 1087);
    pwr_up = 1'b0; cyc(3);
    check("pwr_off_lft", lft1, 0);
    check("pwr_off_rght", rght1, 0);
    pwr_up = 1'b1; cyc(3);
    check("pwr_on_ramp", lft1, -64);
    check("noslew_neg", lft0, -1215);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
